// File: rtl/awmc_pkg.sv
// Stage codes and beep-sequencer encoding shared by the
// AWMC cycle controller and the actuator driver.
package awmc_pkg;

  typedef enum logic [2:0] {
    ST_FILL    = 3'b000,
    ST_WASH    = 3'b001,
    ST_DRAIN1  = 3'b010,
    ST_RINSE   = 3'b011,
    ST_DRAIN2  = 3'b100,
    ST_SPIN    = 3'b101,
    ST_ILLEGAL = 3'b110,
    ST_IDLE    = 3'b111
  } stage_e;

  typedef enum logic [1:0] {
    B_IDLE = 2'b00,
    B_ON   = 2'b01,
    B_OFF  = 2'b10
  } beep_e;

  // Hold, advance one step, park in IDLE, or launch from IDLE.
  function automatic logic seq_legal(stage_e p, stage_e c);
    if (c == ST_ILLEGAL) return 1'b0;
    if (c == p || c == ST_IDLE) return 1'b1;
    if (p == ST_IDLE) return 1'b1;
    if (p <= ST_DRAIN2 && c == stage_e'(p + 3'd1))
      return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/awmc_beeper.sv
// End-of-cycle beep sequencer: BEEP_COUNT beeps of
// BEEP_LEN on / BEEP_LEN off; hold forces a steady tone.
module awmc_beeper
  import awmc_pkg::*;
#(
  parameter int BEEP_LEN   = 2,
  parameter int BEEP_COUNT = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  input  logic abort,
  input  logic hold,
  output logic buzzer
);

  localparam int CW = $clog2(BEEP_LEN + 1);
  localparam int NW = $clog2(BEEP_COUNT + 1);

  beep_e         st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic          buz_q, buz_d;
  logic          ph_end;

  assign ph_end = cnt_q == CW'(BEEP_LEN - 1);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    n_d   = n_q;
    if (hold) begin
      st_d  = B_IDLE;
      cnt_d = '0;
      n_d   = '0;
    end else begin
      case (st_q)
        B_IDLE: if (trigger) begin
          st_d  = B_ON;
          cnt_d = '0;
          n_d   = '0;
        end
        B_ON: begin
          if (abort) begin
            st_d  = B_IDLE;
            cnt_d = '0;
          end else if (ph_end) begin
            cnt_d = '0;
            if (n_q == NW'(BEEP_COUNT - 1)) begin
              st_d = B_IDLE;
            end else begin
              st_d = B_OFF;
              n_d  = n_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        B_OFF: begin
          if (abort) begin
            st_d  = B_IDLE;
            cnt_d = '0;
          end else if (ph_end) begin
            st_d  = B_ON;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: st_d = B_IDLE;
      endcase
    end
    buz_d = hold | (st_d == B_ON);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= B_IDLE;
      cnt_q <= '0;
      n_q   <= '0;
      buz_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      n_q   <= n_d;
      buz_q <= buz_d;
    end
  end

  assign buzzer = buz_q;

endmodule

// File: rtl/awmc_actuator_driver.sv
// Washer actuator driver: registered stage decode, agitation,
// door-lock hold, sequence fault monitor and beep sequencer.
module awmc_actuator_driver
  import awmc_pkg::*;
#(
  parameter int AGIT_PERIOD  = 4,
  parameter int UNLOCK_DELAY = 8,
  parameter int BEEP_LEN     = 2,
  parameter int BEEP_COUNT   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       valve_on,
  output logic       pump_on,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       buzzer,
  output logic       fault
);

  localparam int AW = $clog2(AGIT_PERIOD + 1);
  localparam int UW = $clog2(UNLOCK_DELAY + 1);

  stage_e        stage_q, prev_q;
  logic          done_q, done_qq;
  logic          fault_q, fault_d;
  logic [AW-1:0] agit_q, agit_d;
  logic          dir_q, dir_d;
  logic [UW-1:0] ucnt_q, ucnt_d;
  logic          valve_q, valve_d;
  logic          pump_q, pump_d;
  logic          men_q, men_d;
  logic          fast_q, fast_d;
  logic          lock_q, lock_d;
  logic          agit, idle, trig;

  assign idle    = stage_q == ST_IDLE;
  assign trig    = done_q & ~done_qq;
  assign fault_d = fault_q | ~seq_legal(prev_q, stage_q);

  // Agitation runs AGIT_PERIOD on-cycles then one dead
  // cycle where the direction flips.
  always_comb begin
    valve_d = 1'b0;
    pump_d  = 1'b0;
    men_d   = 1'b0;
    fast_d  = 1'b0;
    agit    = 1'b0;
    agit_d  = '0;
    dir_d   = 1'b0;
    if (!fault_d) begin
      unique case (stage_q)
        ST_FILL:   valve_d = 1'b1;
        ST_DRAIN1,
        ST_DRAIN2: pump_d = 1'b1;
        ST_WASH,
        ST_RINSE:  agit = 1'b1;
        ST_SPIN: begin
          pump_d = 1'b1;
          men_d  = 1'b1;
          fast_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (agit) begin
      if (agit_q == AW'(AGIT_PERIOD)) begin
        dir_d = ~dir_q;
      end else begin
        agit_d = agit_q + 1'b1;
        men_d  = 1'b1;
        dir_d  = dir_q;
      end
    end
  end

  always_comb begin
    ucnt_d = ucnt_q;
    lock_d = fault_d | ~idle;
    if (!idle) begin
      ucnt_d = UW'(UNLOCK_DELAY);
    end else if (ucnt_q != '0) begin
      ucnt_d = ucnt_q - 1'b1;
      lock_d = lock_d | (ucnt_q > UW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= ST_IDLE;
      prev_q  <= ST_IDLE;
      done_q  <= 1'b0;
      done_qq <= 1'b0;
      fault_q <= 1'b0;
      agit_q  <= '0;
      dir_q   <= 1'b0;
      ucnt_q  <= '0;
      valve_q <= 1'b0;
      pump_q  <= 1'b0;
      men_q   <= 1'b0;
      fast_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      stage_q <= stage_e'(stage);
      prev_q  <= stage_q;
      done_q  <= done;
      done_qq <= done_q;
      fault_q <= fault_d;
      agit_q  <= agit_d;
      dir_q   <= dir_d;
      ucnt_q  <= ucnt_d;
      valve_q <= valve_d;
      pump_q  <= pump_d;
      men_q   <= men_d;
      fast_q  <= fast_d;
      lock_q  <= lock_d;
    end
  end

  awmc_beeper #(
    .BEEP_LEN  (BEEP_LEN),
    .BEEP_COUNT(BEEP_COUNT)
  ) u_beeper (
    .clk    (clk),
    .reset_n(reset_n),
    .trigger(trig),
    .abort  (~idle),
    .hold   (fault_d),
    .buzzer (buzzer)
  );

  assign valve_on   = valve_q;
  assign pump_on    = pump_q;
  assign motor_en   = men_q;
  assign motor_dir  = dir_q;
  assign motor_fast = fast_q;
  assign door_lock  = lock_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_awmc_actuator_driver.sv
// Directed bench for awmc_actuator_driver with default
// parameters; inputs driven and outputs sampled 1ns after posedge.
module tb_awmc_actuator_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] stage;
  logic       done;
  logic       valve_on, pump_on, motor_en, motor_dir;
  logic       motor_fast, door_lock, buzzer, fault;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  seq     [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [3:0]  act_exp [6] = '{4'b1000, 4'b0010, 4'b0100,
                               4'b0010, 4'b0100, 4'b0111};
  logic [14:0] bz1   = 15'b000110011001100;
  logic [17:0] men_t = 18'b01_1110_0011_1011_1100;
  logic [17:0] dir_t = 18'b10_0000_0011_1100_0000;
  logic [16:0] bz2   = 17'b0_0000_0000_0100_1100;

  awmc_actuator_driver dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stage     (stage),
    .done      (done),
    .valve_on  (valve_on),
    .pump_on   (pump_on),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .motor_fast(motor_fast),
    .door_lock (door_lock),
    .buzzer    (buzzer),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  assign outs = {valve_on, pump_on, motor_en, motor_dir,
                 motor_fast, door_lock, buzzer, fault};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stage   = 3'b111;
    done    = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    stage   = 3'b111;
    done    = 1'b0;
    #1;
    chk("rst_async", outs, 8'h00);
    cyc(2);
    chk("rst_hold", outs, 8'h00);
    reset_n = 1'b1;

    // full programme, then done pulse with stage IDLE
    for (int s = 0; s < 6; s++) begin
      stage = seq[s];
      cyc(2);
      chk("stage_act", {valve_on, pump_on, motor_en, motor_fast},
          act_exp[s]);
      chk("stage_flt", fault, 1'b0);
      cyc(2);
    end
    stage = 3'b111;
    done  = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      if (i == 1) done = 1'b0;
      chk("beep3", buzzer, bz1[i]);
      chk("end_lock", door_lock, i <= 8);
    end
    chk("end_flt", fault, 1'b0);

    // steady WASH agitation
    do_reset();
    stage = 3'b001;
    cyc(1);
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      chk("wash_en", motor_en, (j % 5) != 4);
      chk("wash_dir", motor_dir, ((j + 1) / 5) % 2);
      chk("wash_fast", motor_fast, 1'b0);
    end

    // RINSE paused to IDLE for 3 cycles, then resumed
    do_reset();
    stage = 3'b011;
    for (int i = 1; i <= 17; i++) begin
      cyc(1);
      if (i >= 2) begin
        chk("pause_lock", door_lock, 1'b1);
        chk("pause_en", motor_en, men_t[i]);
        chk("pause_dir", motor_dir, dir_t[i]);
      end
      if (i == 8) stage = 3'b111;
      if (i == 11) stage = 3'b011;
    end
    chk("pause_flt", fault, 1'b0);

    // skipped stage DRAIN1 -> DRAIN2
    do_reset();
    stage = 3'b010;
    cyc(4);
    stage = 3'b100;
    cyc(1);
    chk("skip_pre_pump", pump_on, 1'b1);
    chk("skip_pre_flt", fault, 1'b0);
    cyc(1);
    chk("skip_flt", fault, 1'b1);
    chk("skip_act", {valve_on, pump_on, motor_en, motor_fast}, 4'b0);
    chk("skip_lock", door_lock, 1'b1);
    chk("skip_buz", buzzer, 1'b1);
    stage = 3'b111;
    cyc(4);
    chk("sticky", {door_lock, buzzer, fault}, 3'b111);
    reset_n = 1'b0;
    #1;
    chk("midrst", outs, 8'h00);

    // first transition after reset is legal
    do_reset();
    stage = 3'b101;
    cyc(2);
    chk("post_rst_flt", fault, 1'b0);
    chk("post_rst_pump", pump_on, 1'b1);

    // illegal code 110
    do_reset();
    stage = 3'b110;
    cyc(1);
    chk("ill_pre", fault, 1'b0);
    cyc(1);
    chk("ill_flt", fault, 1'b1);
    chk("ill_act", {valve_on, pump_on, motor_en, motor_fast}, 4'b0);
    chk("ill_lock_buz", {door_lock, buzzer}, 2'b11);

    // done + IDLE together, beeps aborted by FILL, relock
    do_reset();
    stage = 3'b101;
    cyc(4);
    stage = 3'b111;
    done  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (i == 1) done = 1'b0;
      chk("abort_buz", buzzer, bz2[i]);
      chk("abort_lock", door_lock, i < 16);
      if (i == 5) stage = 3'b000;
      if (i == 7) stage = 3'b111;
    end
    chk("abort_flt", fault, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
